id_ex_reg: RTL and testbench
============================

# id_ex_reg

Pipeline register between the decode stage (register file, sign extender, `control_unit`) and the execute stage (ALU, ALU control, forwarding muxes). On each enabled clock edge it captures the decode-stage control word and operands and presents them, registered, to execute. It also provides the two pipeline-control behaviours execute depends on:

- **hold**: the debug unit's step enable is low, so the register keeps its contents.
- **bubble**: the hazard unit requests a flush, so a NOP is inserted with all side-effecting controls cleared.

## Interface

Parameters:
- `NB_PC`, 32, PC+4 width
- `NB_DATA`, 32, register and immediate data width
- `NB_REG`, 5, register address width
- `NB_OPCODE`, 6, alu_op width (opcode passthrough from `control_unit`)
- `NB_FUNCT`, 6, funct field width

Ports:
- `i_clock`  in  1  single clock; all state updates on the rising edge
- `i_reset`  in  1  asynchronous, active-high reset
- `i_enable`  in  1  pipeline step enable (debug unit); low = hold
- `i_flush`  in  1  insert bubble (hazard unit, load-use stall or taken branch)
- `i_reg_dest`, `i_alu_src`, `i_mem_read`, `i_mem_write`, `i_branch`, `i_reg_write`, `i_mem_to_reg`  in  1 each  control bits from `control_unit`
- `i_alu_op`  in  `NB_OPCODE`  ALU op / opcode from `control_unit`
- `i_pc`  in  `NB_PC`  PC+4 of the decoded instruction
- `i_data_a`, `i_data_b`  in  `NB_DATA`  register file read data (rs, rt)
- `i_immediate`  in  `NB_DATA`  sign-extended immediate
- `i_funct`  in  `NB_FUNCT`  instruction[5:0]
- `i_rs`, `i_rt`, `i_rd`  in  `NB_REG`  register addresses
- `o_*`: one registered output per input above, same name with the `o_` prefix and the same width
- `o_valid`  out  1  high when the execute-stage slot holds a real instruction, low for reset or bubble

## Operation

- State is the registered copy of every `i_*` field plus `o_valid`. There is no other state.
- **Per-edge priority**, highest first:
  1. `i_reset`: clear everything.
  2. `i_enable` low: hold all outputs. `i_flush` is ignored.
  3. `i_flush` high: load a bubble.
  4. Otherwise: load all inputs and set `o_valid` = 1.
- **Bubble load**:
  - Forced to 0: `o_reg_write`, `o_mem_read`, `o_mem_write`, `o_branch`, `o_mem_to_reg`, `o_valid`.
  - Captured normally: `o_alu_op`, `o_alu_src`, `o_reg_dest`, and all data/address fields. This keeps execute-stage combinational paths deterministic; the bubble is harmless because no write or branch enable is set.
- No arithmetic is performed; every field passes through at its declared width with no truncation or extension.
- `o_valid` is the only bit not sourced from an input. It is 1 exactly when the last enabled edge without reset was a non-flush load.

## Timing

- **Reset value**: every output is 0, including `o_valid`, `o_alu_op` = 6'h00 and `o_pc` = 0. Outputs go to 0 immediately on `i_reset` assertion, with no clock needed.
- **Reset release**: outputs stay 0 until the first rising edge with `i_enable` = 1.
- **Latency**: 1 cycle. Inputs sampled at edge N appear on outputs after edge N and are stable for the whole following cycle.
- **No combinational path** from any input to any output.
- **Flush**: lasts exactly the edges on which it is sampled high with `i_enable` high. A flush held for k enabled edges yields k consecutive bubbles.
- **Enable low for M cycles**: outputs are frozen for M cycles, then resume on the next enabled edge with whatever inputs are present at that edge. Nothing is queued.
- **Reset mid-stream** (asserted between edges): outputs clear asynchronously. The in-flight instruction is discarded, not replayed.
- **Simultaneous events**:
  - `i_flush` and `i_enable` both high: bubble.
  - `i_flush` high with `i_enable` low: hold.
  - `i_reset` together with anything else: reset.

## Test plan

- **Reset**: assert `i_reset` mid-cycle with the register holding an LW (`i_alu_op` = 6'h23, `mem_read` = 1) → all outputs 0 immediately, before the next edge. Release reset with `i_enable` = 0 → outputs remain 0.
- **Passthrough**: `i_enable` = 1, then per edge present R-type (6'h00, `reg_dest` = 1, `reg_write` = 1, `funct` = 6'h21, rs/rt/rd = 1/2/3), then ADDI (6'h08, `alu_src` = 1, imm = 32'hFFFF_FFFC), then SW (6'h2b, `mem_write` = 1) → each appears on the outputs exactly one edge later with identical values and `o_valid` = 1.
- **Bubble**: present LW (6'h23, `mem_read`/`mem_to_reg`/`reg_write` = 1) with `i_flush` = 1 for one edge → `o_reg_write` = `o_mem_read` = `o_mem_to_reg` = `o_mem_write` = `o_branch` = `o_valid` = 0 and `o_alu_op` = 6'h23. On the next edge, with flush low, the same LW appears with `o_valid` = 1.
- **Hold**: load BEQ (6'h04, `branch` = 1), then drop `i_enable` for 3 cycles while driving BNE and `i_flush` = 1 → outputs stay BEQ with `o_branch` = 1 and `o_valid` = 1. On re-enable with flush low and BNE (6'h05) driven, outputs show BNE.
- **Back-to-back flush**: `i_flush` high for 2 enabled edges → 2 bubbles (`o_valid` = 0). The third edge loads normally.
- **Width check**: drive all-ones on every data/address input, then all-zeros → outputs match bit-for-bit: `o_pc`/`o_data_a`/`o_data_b`/`o_immediate` = 32'hFFFF_FFFF, `o_rs`/`o_rt`/`o_rd` = 5'h1F, then all 0.

Source files
------------

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: captures decode-stage control and operands for execute,
// with debug-step hold and hazard-unit bubble insertion.
module id_ex_reg #(
   parameter int NB_PC     = 32,
   parameter int NB_DATA   = 32,
   parameter int NB_REG    = 5,
   parameter int NB_OPCODE = 6,
   parameter int NB_FUNCT  = 6
) (
   input  logic                 i_clock,
   input  logic                 i_reset,
   input  logic                 i_enable,
   input  logic                 i_flush,
   input  logic                 i_reg_dest,
   input  logic                 i_alu_src,
   input  logic                 i_mem_read,
   input  logic                 i_mem_write,
   input  logic                 i_branch,
   input  logic                 i_reg_write,
   input  logic                 i_mem_to_reg,
   input  logic [NB_OPCODE-1:0] i_alu_op,
   input  logic [NB_PC-1:0]     i_pc,
   input  logic [NB_DATA-1:0]   i_data_a,
   input  logic [NB_DATA-1:0]   i_data_b,
   input  logic [NB_DATA-1:0]   i_immediate,
   input  logic [NB_FUNCT-1:0]  i_funct,
   input  logic [NB_REG-1:0]    i_rs,
   input  logic [NB_REG-1:0]    i_rt,
   input  logic [NB_REG-1:0]    i_rd,
   output logic                 o_reg_dest,
   output logic                 o_alu_src,
   output logic                 o_mem_read,
   output logic                 o_mem_write,
   output logic                 o_branch,
   output logic                 o_reg_write,
   output logic                 o_mem_to_reg,
   output logic [NB_OPCODE-1:0] o_alu_op,
   output logic [NB_PC-1:0]     o_pc,
   output logic [NB_DATA-1:0]   o_data_a,
   output logic [NB_DATA-1:0]   o_data_b,
   output logic [NB_DATA-1:0]   o_immediate,
   output logic [NB_FUNCT-1:0]  o_funct,
   output logic [NB_REG-1:0]    o_rs,
   output logic [NB_REG-1:0]    o_rt,
   output logic [NB_REG-1:0]    o_rd,
   output logic                 o_valid
);

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         o_reg_dest   <= 1'b0;
         o_alu_src    <= 1'b0;
         o_mem_read   <= 1'b0;
         o_mem_write  <= 1'b0;
         o_branch     <= 1'b0;
         o_reg_write  <= 1'b0;
         o_mem_to_reg <= 1'b0;
         o_alu_op     <= '0;
         o_pc         <= '0;
         o_data_a     <= '0;
         o_data_b     <= '0;
         o_immediate  <= '0;
         o_funct      <= '0;
         o_rs         <= '0;
         o_rt         <= '0;
         o_rd         <= '0;
         o_valid      <= 1'b0;
      end else if (i_enable) begin
         // Non-side-effecting fields load even on a bubble so execute sees defined operands.
         o_reg_dest  <= i_reg_dest;
         o_alu_src   <= i_alu_src;
         o_alu_op    <= i_alu_op;
         o_pc        <= i_pc;
         o_data_a    <= i_data_a;
         o_data_b    <= i_data_b;
         o_immediate <= i_immediate;
         o_funct     <= i_funct;
         o_rs        <= i_rs;
         o_rt        <= i_rt;
         o_rd        <= i_rd;
         if (i_flush) begin
            o_mem_read   <= 1'b0;
            o_mem_write  <= 1'b0;
            o_branch     <= 1'b0;
            o_reg_write  <= 1'b0;
            o_mem_to_reg <= 1'b0;
            o_valid      <= 1'b0;
         end else begin
            o_mem_read   <= i_mem_read;
            o_mem_write  <= i_mem_write;
            o_branch     <= i_branch;
            o_reg_write  <= i_reg_write;
            o_mem_to_reg <= i_mem_to_reg;
            o_valid      <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg: expected output words are queued at drive time
// and compared one edge later against the registered outputs.
module tb_id_ex_reg;

   typedef struct packed {
      logic        reg_dest;
      logic        alu_src;
      logic        mem_read;
      logic        mem_write;
      logic        branch;
      logic        reg_write;
      logic        mem_to_reg;
      logic [5:0]  alu_op;
      logic [31:0] pc;
      logic [31:0] data_a;
      logic [31:0] data_b;
      logic [31:0] immediate;
      logic [5:0]  funct;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
   } fields_t;

   typedef struct packed {
      fields_t f;
      logic    valid;
   } out_t;

   logic    clk = 1'b0;
   logic    rst = 1'b1;
   logic    en  = 1'b0;
   logic    fl  = 1'b0;
   fields_t in_s = '0;
   out_t    got;
   out_t    mdl = '0;
   out_t    exp_q[$];
   int      total = 0;
   int      bad = 0;

   always #5 clk = ~clk;

   id_ex_reg #(
      .NB_PC(32), .NB_DATA(32), .NB_REG(5), .NB_OPCODE(6), .NB_FUNCT(6)
   ) dut (
      .i_clock(clk), .i_reset(rst), .i_enable(en), .i_flush(fl),
      .i_reg_dest(in_s.reg_dest), .i_alu_src(in_s.alu_src),
      .i_mem_read(in_s.mem_read), .i_mem_write(in_s.mem_write),
      .i_branch(in_s.branch), .i_reg_write(in_s.reg_write),
      .i_mem_to_reg(in_s.mem_to_reg), .i_alu_op(in_s.alu_op),
      .i_pc(in_s.pc), .i_data_a(in_s.data_a), .i_data_b(in_s.data_b),
      .i_immediate(in_s.immediate), .i_funct(in_s.funct),
      .i_rs(in_s.rs), .i_rt(in_s.rt), .i_rd(in_s.rd),
      .o_reg_dest(got.f.reg_dest), .o_alu_src(got.f.alu_src),
      .o_mem_read(got.f.mem_read), .o_mem_write(got.f.mem_write),
      .o_branch(got.f.branch), .o_reg_write(got.f.reg_write),
      .o_mem_to_reg(got.f.mem_to_reg), .o_alu_op(got.f.alu_op),
      .o_pc(got.f.pc), .o_data_a(got.f.data_a), .o_data_b(got.f.data_b),
      .o_immediate(got.f.immediate), .o_funct(got.f.funct),
      .o_rs(got.f.rs), .o_rt(got.f.rt), .o_rd(got.f.rd),
      .o_valid(got.valid)
   );

   function automatic out_t next_model(out_t cur, fields_t in, logic enable, logic flush);
      out_t n;
      if (!enable) return cur;
      n.f = in;
      n.valid = 1'b1;
      if (flush) begin
         n.f.mem_read   = 1'b0;
         n.f.mem_write  = 1'b0;
         n.f.branch     = 1'b0;
         n.f.reg_write  = 1'b0;
         n.f.mem_to_reg = 1'b0;
         n.valid        = 1'b0;
      end
      return n;
   endfunction

   task automatic check(input string tag, input out_t exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Queue the expectation for the coming edge, then compare just after it.
   task automatic step(input string tag);
      mdl = next_model(mdl, in_s, en, fl);
      exp_q.push_back(mdl);
      @(posedge clk);
      #1;
      check(tag, exp_q.pop_front());
   endtask

   task automatic set_ctl(input logic rd_, input logic as, input logic mr, input logic mw,
                          input logic br, input logic rw, input logic m2r, input logic [5:0] op);
      in_s.reg_dest = rd_; in_s.alu_src = as; in_s.mem_read = mr; in_s.mem_write = mw;
      in_s.branch = br; in_s.reg_write = rw; in_s.mem_to_reg = m2r; in_s.alu_op = op;
   endtask

   task automatic set_data(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] imm, input logic [5:0] fn,
                           input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
      in_s.pc = pc; in_s.data_a = a; in_s.data_b = b; in_s.immediate = imm;
      in_s.funct = fn; in_s.rs = rs; in_s.rt = rt; in_s.rd = rd;
   endtask

   initial begin
      // Reset asserted from time 0; release with enable low keeps outputs at zero.
      #2;
      check("reset_initial", '0);
      set_ctl(1, 1, 1, 1, 1, 1, 1, 6'h3f);
      set_data(32'h100, 32'h11, 32'h22, 32'h33, 6'h2a, 5'd4, 5'd5, 5'd6);
      @(posedge clk); #1;
      rst = 1'b0;
      step("hold_after_reset_1");
      step("hold_after_reset_2");

      // Passthrough: R-type, ADDI, SW.
      en = 1'b1;
      set_ctl(1, 0, 0, 0, 0, 1, 0, 6'h00);
      set_data(32'h0000_0004, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0, 6'h21, 5'd1, 5'd2, 5'd3);
      step("rtype");
      set_ctl(0, 1, 0, 0, 0, 1, 0, 6'h08);
      set_data(32'h0000_0008, 32'h0000_0010, 32'h0, 32'hFFFF_FFFC, 6'h3c, 5'd7, 5'd8, 5'd0);
      step("addi");
      set_ctl(0, 1, 0, 1, 0, 0, 0, 6'h2b);
      set_data(32'h0000_000C, 32'h0000_2000, 32'hCAFE_F00D, 32'h0000_0004, 6'h04, 5'd9, 5'd10, 5'd0);
      step("sw");

      // Load an LW, then reset mid-cycle: outputs must clear without a clock edge.
      set_ctl(0, 1, 1, 0, 0, 1, 1, 6'h23);
      set_data(32'h0000_0010, 32'h0000_3000, 32'h0, 32'h0000_0008, 6'h08, 5'd11, 5'd12, 5'd0);
      step("lw_before_reset");
      #2;
      rst = 1'b1;
      #1;
      check("reset_async", '0);
      mdl = '0;
      @(posedge clk); #1;
      check("reset_held_over_edge", '0);
      en = 1'b0;
      rst = 1'b0;
      step("reset_release_enable_low");

      // Bubble then the same LW as a real load.
      en = 1'b1;
      fl = 1'b1;
      step("lw_bubble");
      check_bit("bubble_valid", got.valid, 1'b0);
      fl = 1'b0;
      step("lw_after_bubble");
      check_bit("lw_valid", got.valid, 1'b1);

      // Hold: BEQ stays while enable is low, even with flush and BNE driven.
      set_ctl(0, 0, 0, 0, 1, 0, 0, 6'h04);
      set_data(32'h0000_0014, 32'h5, 32'h5, 32'h0000_0010, 6'h10, 5'd13, 5'd14, 5'd0);
      step("beq");
      en = 1'b0;
      fl = 1'b1;
      set_ctl(0, 0, 0, 0, 1, 0, 0, 6'h05);
      set_data(32'h0000_0018, 32'h6, 32'h7, 32'h0000_0020, 6'h20, 5'd15, 5'd16, 5'd0);
      for (int unsigned i = 0; i < 3; i++) step("hold_beq");
      check_bit("hold_branch", got.f.branch, 1'b1);
      en = 1'b1;
      fl = 1'b0;
      step("bne_resume");

      // Back-to-back flush gives two bubbles, then a normal load.
      fl = 1'b1;
      set_ctl(1, 0, 0, 0, 0, 1, 0, 6'h00);
      set_data(32'h0000_001C, 32'hA, 32'hB, 32'h0, 6'h22, 5'd17, 5'd18, 5'd19);
      step("flush_1");
      set_data(32'h0000_0020, 32'hC, 32'hD, 32'h0, 6'h24, 5'd20, 5'd21, 5'd22);
      step("flush_2");
      fl = 1'b0;
      step("after_flush");

      // Width check: all ones, then all zeros.
      set_ctl(1, 1, 1, 1, 1, 1, 1, 6'h3f);
      set_data('1, '1, '1, '1, '1, '1, '1, '1);
      step("all_ones");
      check_bit("all_ones_pc_msb", got.f.pc[31], 1'b1);
      set_ctl(0, 0, 0, 0, 0, 0, 0, 6'h00);
      set_data('0, '0, '0, '0, '0, '0, '0, '0);
      step("all_zeros");

      // Reset coinciding with an enabled edge wins.
      set_ctl(0, 1, 1, 0, 0, 1, 1, 6'h23);
      set_data(32'h44, 32'h55, 32'h66, 32'h77, 6'h01, 5'd1, 5'd1, 5'd1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      check("reset_with_enable", '0);
      rst = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
